// File: rtl/core_pkg.sv
// Shared RV64I core types: datapath widths, ALU encodings and the ID/EX payload.
// Latency: none (declarations only).
// Backpressure: not applicable.
package core_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0]   op0;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   rs2_data;
        logic [REG_AW-1:0] rd;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [5:0]        ctrl;
        logic              is_load;
    } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Source-operand bypass select: x0, then EX/MEM, then MEM/WB, then register file.
// Latency: purely combinational.
// Backpressure: none; the caller samples the result when it captures.
module fwd_mux #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [XLEN-1:0]   rf_dat,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_dat,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_dat,
    output logic [XLEN-1:0]   sel_dat
);

    always_comb begin
        sel_dat = rf_dat;
        if (idx == '0) begin
            sel_dat = '0;
        end else if (mem_wen && (mem_rd == idx)) begin
            sel_dat = mem_dat;
        end else if (wb_wen && (wb_rd == idx)) begin
            sel_dat = wb_dat;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register: forwards operands, picks imm/rs2 for op1, bubbles on load-use; ID_EX_PERF_EN adds counters.
// Latency: 1 cycle from decode accept to ex_valid; 1 instruction/cycle without hazards.
// Backpressure: holds while ex_valid && !ex_ready; dec_ready drops on hold, hazard or flush.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int REG_AW = core_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [XLEN-1:0]   dec_rs1_data,
    input  logic [XLEN-1:0]   dec_rs2_data,
    input  logic [XLEN-1:0]   dec_imm,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_use_imm,
    input  logic              dec_is_load,
    input  logic [2:0]        dec_func3,
    input  logic [6:0]        dec_func7,
    input  logic [5:0]        dec_ctrl,
    input  logic              fwd_mem_wen,
    input  logic [REG_AW-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]   fwd_mem_data,
    input  logic              fwd_wb_wen,
    input  logic [REG_AW-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]   fwd_wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_op0,
    output logic [XLEN-1:0]   ex_op1,
    output logic [2:0]        ex_func3,
    output logic [6:0]        ex_func7,
    output logic [5:0]        ex_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic [XLEN-1:0]   ex_rs2_data,
`ifdef ID_EX_PERF_EN
    output logic [31:0]       perf_bubbles,
    output logic [31:0]       perf_flushes,
`endif
    output logic              ex_is_load
);

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    logic            ex_vld_q;
    logic [XLEN-1:0] rs1_fwd_dat;
    logic [XLEN-1:0] rs2_fwd_dat;
    logic            advance;
    logic            hazard;
    logic            accept;

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .idx     (dec_rs1),
        .rf_dat  (dec_rs1_data),
        .mem_wen (fwd_mem_wen),
        .mem_rd  (fwd_mem_rd),
        .mem_dat (fwd_mem_data),
        .wb_wen  (fwd_wb_wen),
        .wb_rd   (fwd_wb_rd),
        .wb_dat  (fwd_wb_data),
        .sel_dat (rs1_fwd_dat)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .idx     (dec_rs2),
        .rf_dat  (dec_rs2_data),
        .mem_wen (fwd_mem_wen),
        .mem_rd  (fwd_mem_rd),
        .mem_dat (fwd_mem_data),
        .wb_wen  (fwd_wb_wen),
        .wb_rd   (fwd_wb_rd),
        .wb_dat  (fwd_wb_data),
        .sel_dat (rs2_fwd_dat)
    );

    // A load's result is only bypassable from EX/MEM, so a dependent must wait one cycle.
    assign advance = !ex_vld_q || ex_ready;
    assign hazard  = ex_vld_q && ex_q.is_load && (ex_q.rd != '0) && dec_valid &&
                     ((dec_rs1 == ex_q.rd) || (!dec_use_imm && (dec_rs2 == ex_q.rd)));
    assign dec_ready = advance && !hazard && !flush;
    assign accept    = dec_valid && dec_ready;

    always_comb begin
        ex_d          = '0;
        ex_d.op0      = rs1_fwd_dat;
        ex_d.op1      = dec_use_imm ? dec_imm : rs2_fwd_dat;
        ex_d.rs2_data = rs2_fwd_dat;
        ex_d.rd       = dec_rd;
        ex_d.func3    = dec_func3;
        ex_d.func7    = dec_func7;
        ex_d.ctrl     = dec_ctrl;
        ex_d.is_load  = dec_is_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld_q <= 1'b0;
            ex_q     <= '0;
        end else if (flush) begin
            ex_vld_q <= 1'b0;
        end else if (advance) begin
            ex_vld_q <= accept;
            if (accept) begin
                ex_q <= ex_d;
            end
        end
    end

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubbles <= '0;
            perf_flushes <= '0;
        end else begin
            // A bubble is only inserted when the stage actually advances past the load.
            if (hazard && ex_ready && !flush && (perf_bubbles != '1)) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
            if (flush && ex_vld_q && (perf_flushes != '1)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

    assign ex_valid    = ex_vld_q;
    assign ex_op0      = ex_q.op0;
    assign ex_op1      = ex_q.op1;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_rd       = ex_q.rd;
    assign ex_func3    = ex_q.func3;
    assign ex_func7    = ex_q.func7;
    assign ex_ctrl     = ex_q.ctrl;
    assign ex_is_load  = ex_q.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: forwarding vector table plus load-use, stall, flush and async-reset sequences.
// Expected ALU payloads are queued at accept and compared when the execute side consumes them.
module tb_id_ex_stage;
    import core_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              dec_valid;
    logic              dec_ready;
    logic [XLEN-1:0]   dec_rs1_data, dec_rs2_data, dec_imm;
    logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
    logic              dec_use_imm, dec_is_load;
    logic [2:0]        dec_func3;
    logic [6:0]        dec_func7;
    logic [5:0]        dec_ctrl;
    logic              fwd_mem_wen, fwd_wb_wen;
    logic [REG_AW-1:0] fwd_mem_rd, fwd_wb_rd;
    logic [XLEN-1:0]   fwd_mem_data, fwd_wb_data;
    logic              ex_valid, ex_ready;
    logic [XLEN-1:0]   ex_op0, ex_op1, ex_rs2_data;
    logic [2:0]        ex_func3;
    logic [6:0]        ex_func7;
    logic [5:0]        ex_ctrl;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_is_load;
`ifdef ID_EX_PERF_EN
    logic [31:0]       perf_bubbles, perf_flushes;
`endif

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_rs1_data (dec_rs1_data),
        .dec_rs2_data (dec_rs2_data),
        .dec_imm      (dec_imm),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .dec_use_imm  (dec_use_imm),
        .dec_is_load  (dec_is_load),
        .dec_func3    (dec_func3),
        .dec_func7    (dec_func7),
        .dec_ctrl     (dec_ctrl),
        .fwd_mem_wen  (fwd_mem_wen),
        .fwd_mem_rd   (fwd_mem_rd),
        .fwd_mem_data (fwd_mem_data),
        .fwd_wb_wen   (fwd_wb_wen),
        .fwd_wb_rd    (fwd_wb_rd),
        .fwd_wb_data  (fwd_wb_data),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_op0       (ex_op0),
        .ex_op1       (ex_op1),
        .ex_func3     (ex_func3),
        .ex_func7     (ex_func7),
        .ex_ctrl      (ex_ctrl),
        .ex_rd        (ex_rd),
        .ex_rs2_data  (ex_rs2_data),
`ifdef ID_EX_PERF_EN
        .perf_bubbles (perf_bubbles),
        .perf_flushes (perf_flushes),
`endif
        .ex_is_load   (ex_is_load)
    );

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] rs1d, rs2d, imm;
        logic        ui, il;
        logic        mw, ww;
        logic [4:0]  mrd, wrd;
        logic [63:0] md, wd;
        logic [63:0] e0, e1, e2;
    } vec_t;

    typedef struct {
        logic [63:0] e0, e1, e2;
        logic [21:0] ctl;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   total = 0;
    int   passed = 0;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [63:0] rs1d,
                                input logic [4:0] rs2, input logic [63:0] rs2d,
                                input logic ui, input logic [63:0] imm,
                                input logic mw, input logic [4:0] mrd, input logic [63:0] md,
                                input logic ww, input logic [4:0] wrd, input logic [63:0] wd,
                                input logic [4:0] rd, input logic il,
                                input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2);
        vec_t v;
        v.rs1 = rs1; v.rs1d = rs1d; v.rs2 = rs2; v.rs2d = rs2d; v.ui = ui; v.imm = imm;
        v.mw = mw; v.mrd = mrd; v.md = md; v.ww = ww; v.wrd = wrd; v.wd = wd;
        v.rd = rd; v.il = il; v.e0 = e0; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    // Control fields are derived from rd so every instruction carries a distinct pattern.
    function automatic logic [21:0] ctl_of(input vec_t v);
        return {v.rd, v.rd[2:0], {v.rd, 2'b01}, {1'b1, v.rd}, v.il};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        dec_rs1 = v.rs1; dec_rs1_data = v.rs1d; dec_rs2 = v.rs2; dec_rs2_data = v.rs2d;
        dec_use_imm = v.ui; dec_imm = v.imm; dec_rd = v.rd; dec_is_load = v.il;
        dec_func3 = v.rd[2:0]; dec_func7 = {v.rd, 2'b01}; dec_ctrl = {1'b1, v.rd};
        fwd_mem_wen = v.mw; fwd_mem_rd = v.mrd; fwd_mem_data = v.md;
        fwd_wb_wen = v.ww; fwd_wb_rd = v.wrd; fwd_wb_data = v.wd;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.e0 = v.e0; e.e1 = v.e1; e.e2 = v.e2; e.ctl = ctl_of(v);
        sb_q.push_back(e);
    endtask

    // Offers one instruction for one cycle; exp_acc is whether decode should be accepted.
    task automatic issue(input vec_t v, input logic exp_acc, input string nm);
        drive(v);
        dec_valid = 1'b1;
        #1;
        check({nm, "_dec_ready"}, 64'(dec_ready), 64'(exp_acc));
        if (exp_acc) push_exp(v);
        @(posedge clk); #1;
    endtask

    // Scoreboard side: compare whenever the execute stage consumes an instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ex_valid && ex_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    $display("FAIL sb_unexpected: ex_valid=1 op0=%h, expected no instruction", ex_op0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_op0", ex_op0, e.e0);
                    check("sb_op1", ex_op1, e.e1);
                    check("sb_rs2_data", ex_rs2_data, e.e2);
                    check("sb_ctl", 64'({ex_rd, ex_func3, ex_func7, ex_ctrl, ex_is_load}), 64'(e.ctl));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t ld, dep, dep_fwd, imm_use, x, y, z, w, v;

        vecs[0] = mk(5'd1, 64'h5, 5'd2, 64'h7, 1'b0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                     5'd10, 1'b0, 64'h5, 64'h7, 64'h7);
        vecs[1] = mk(5'd3, 64'h33, 5'd6, 64'h66, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 5'd3, 64'hAA,
                     1'b1, 5'd3, 64'hBB, 5'd11, 1'b0, 64'hAA, 64'hFFFF_FFFF_FFFF_FFF0, 64'h66);
        vecs[2] = mk(5'd3, 64'h33, 5'd5, 64'h55, 1'b0, 64'h0, 1'b1, 5'd5, 64'hAA,
                     1'b1, 5'd3, 64'hBB, 5'd12, 1'b0, 64'hBB, 64'hAA, 64'hAA);
        vecs[3] = mk(5'd0, 64'h99, 5'd0, 64'h98, 1'b0, 64'h0, 1'b1, 5'd0, 64'hAA,
                     1'b1, 5'd0, 64'hBB, 5'd13, 1'b0, 64'h0, 64'h0, 64'h0);
        vecs[4] = mk(5'd7, 64'h77, 5'd7, 64'h78, 1'b0, 64'h0, 1'b0, 5'd7, 64'hAA,
                     1'b1, 5'd7, 64'hBB, 5'd14, 1'b0, 64'hBB, 64'hBB, 64'hBB);
        vecs[5] = mk(5'd8, 64'h88, 5'd9, 64'h1234, 1'b0, 64'h0, 1'b1, 5'd1, 64'hAA,
                     1'b0, 5'd8, 64'hBB, 5'd15, 1'b0, 64'h88, 64'h1234, 64'h1234);

        rst_n = 1'b0; flush = 1'b0; dec_valid = 1'b0; ex_ready = 1'b1;
        drive(vecs[0]);
        #1;
        check("rst_ex_valid", 64'(ex_valid), 64'h0);
        check("rst_ex_op0", ex_op0, 64'h0);
        check("rst_ex_op1", ex_op1, 64'h0);
        check("rst_ex_ctl", 64'({ex_rd, ex_func3, ex_func7, ex_ctrl, ex_is_load}), 64'h0);
        check("rst_dec_ready", 64'(dec_ready), 64'h1);
`ifdef ID_EX_PERF_EN
        check("rst_perf", 64'({perf_bubbles, perf_flushes}), 64'h0);
`endif
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) issue(vecs[i], 1'b1, $sformatf("vec%0d", i));

        // Load-use: bubble, then dependent accepted with the load result from EX/MEM.
        ld      = mk(5'd1, 64'h100, 5'd2, 64'h200, 1'b1, 64'h8, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                     5'd4, 1'b1, 64'h100, 64'h8, 64'h200);
        dep     = mk(5'd4, 64'hDEAD, 5'd2, 64'h200, 1'b0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                     5'd5, 1'b0, 64'h0, 64'h0, 64'h0);
        dep_fwd = mk(5'd4, 64'hDEAD, 5'd2, 64'h200, 1'b0, 64'h0, 1'b1, 5'd4, 64'h10, 1'b0, 5'd0, 64'h0,
                     5'd5, 1'b0, 64'h10, 64'h200, 64'h200);
        issue(ld, 1'b1, "lu_load");
        issue(dep, 1'b0, "lu_hazard");
        check("lu_bubble_valid", 64'(ex_valid), 64'h0);
        issue(dep_fwd, 1'b1, "lu_dep");

        // A load followed by an I-type that names the load rd only in the unused rs2 slot.
        ld.rd = 5'd6;
        imm_use = mk(5'd1, 64'h11, 5'd6, 64'h66, 1'b1, 64'h40, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                     5'd7, 1'b0, 64'h11, 64'h40, 64'h66);
        issue(ld, 1'b1, "imm_load");
        issue(imm_use, 1'b1, "imm_nohaz");
        dec_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("drain_valid", 64'(ex_valid), 64'h0);

        // Stall: outputs frozen while the execute stage refuses.
        x = mk(5'd9, 64'h900, 5'd10, 64'hA00, 1'b0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
               5'd16, 1'b0, 64'h900, 64'hA00, 64'hA00);
        y = mk(5'd11, 64'hB00, 5'd12, 64'hC00, 1'b0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
               5'd17, 1'b0, 64'hB00, 64'hC00, 64'hC00);
        ex_ready = 1'b0;
        issue(x, 1'b1, "stall_x");
        drive(y);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_dec_ready", 64'(dec_ready), 64'h0);
            check("stall_valid", 64'(ex_valid), 64'h1);
            check("stall_op0", ex_op0, 64'h900);
            check("stall_op1", ex_op1, 64'hA00);
            @(posedge clk); #1;
        end
        ex_ready = 1'b1;
        #1;
        check("unstall_dec_ready", 64'(dec_ready), 64'h1);
        push_exp(y);
        @(posedge clk); #1;

        // Flush with an instruction both in EX and on offer: nothing is captured.
        z = mk(5'd13, 64'hD00, 5'd14, 64'hE00, 1'b0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
               5'd18, 1'b0, 64'hD00, 64'hE00, 64'hE00);
        drive(z);
        flush = 1'b1;
        #1;
        check("flush_dec_ready", 64'(dec_ready), 64'h0);
        @(posedge clk); #1;
        check("flush_valid", 64'(ex_valid), 64'h0);
`ifdef ID_EX_PERF_EN
        check("perf_flushes", 64'(perf_flushes), 64'h1);
        check("perf_bubbles", 64'(perf_bubbles), 64'h1);
`endif
        flush = 1'b0;
        dec_valid = 1'b0;
        @(posedge clk); #1;
        check("post_flush_valid", 64'(ex_valid), 64'h0);

        // Asynchronous reset between clock edges drops the in-flight instruction.
        w = mk(5'd15, 64'hF00, 5'd16, 64'h1600, 1'b0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
               5'd19, 1'b0, 64'hF00, 64'h1600, 64'h1600);
        ex_ready = 1'b0;
        issue(w, 1'b1, "arst_w");
        dec_valid = 1'b0;
        check("arst_pre_valid", 64'(ex_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(ex_valid), 64'h0);
        check("arst_op0", ex_op0, 64'h0);
        check("arst_rs2_data", ex_rs2_data, 64'h0);
`ifdef ID_EX_PERF_EN
        check("arst_perf", 64'({perf_bubbles, perf_flushes}), 64'h0);
`endif
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ex_ready = 1'b1;

        v = mk(5'd20, 64'h2000, 5'd21, 64'h2100, 1'b1, 64'h7FF, 1'b0, 5'd0, 64'h0, 1'b1, 5'd21, 64'h55,
               5'd22, 1'b0, 64'h2000, 64'h7FF, 64'h55);
        issue(v, 1'b1, "post_rst");
        dec_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the RV64I core, directly upstream of the ALU.
- Captures decoded instructions and resolves operand forwarding from EX/MEM and MEM/WB.
- Selects immediate vs register for op1, detects load-use hazards and inserts bubbles.
- Presents registered op0/op1/func3/func7/ctrl to the ALU under a valid/ready handshake.

Parameters:
XLEN, 64, operand/data width
REG_AW, 5, register index width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush (branch mispredict / trap)
dec_valid  in  1  decode offers an instruction
dec_ready  out  1  stage accepts the offered instruction this cycle
dec_rs1_data  in  XLEN  register-file read of rs1
dec_rs2_data  in  XLEN  register-file read of rs2
dec_imm  in  XLEN  sign-extended immediate
dec_rs1, dec_rs2, dec_rd  in  REG_AW each  register indices
dec_use_imm  in  1  op1 = immediate (I-type)
dec_is_load  in  1  instruction is a load
dec_func3  in  3  ALU func3
dec_func7  in  7  ALU func7
dec_ctrl  in  6  ALU ctrl field
fwd_mem_wen  in  1  EX/MEM writes a register
fwd_mem_rd  in  REG_AW  EX/MEM destination
fwd_mem_data  in  XLEN  EX/MEM result
fwd_wb_wen  in  1  MEM/WB writes a register
fwd_wb_rd  in  REG_AW  MEM/WB destination
fwd_wb_data  in  XLEN  MEM/WB result
ex_valid  out  1  ALU inputs valid
ex_ready  in  1  execute stage consumes this cycle
ex_op0, ex_op1  out  XLEN  ALU operands
ex_func3 / ex_func7 / ex_ctrl  out  3 / 7 / 6  ALU control
ex_rd  out  REG_AW  destination for downstream
ex_rs2_data  out  XLEN  forwarded rs2 (store data)
ex_is_load  out  1  load marker for hazard/downstream

Behaviour:
- Reset (rst_n=0, async): ex_valid=0; all ex_* data/control outputs = 0.
- Handshake: register advances when !ex_valid || ex_ready. Accept = dec_valid && dec_ready; a transfer occurs on the clk edge when both are high.
- dec_ready = (!ex_valid || ex_ready) && !hazard && !flush.
- Load-use hazard = ex_valid && ex_is_load && ex_rd!=0 && dec_valid && (dec_rs1==ex_rd || (!dec_use_imm && dec_rs2==ex_rd)).
  - On hazard with ex_ready=1, the register loads a bubble: ex_valid=0 next cycle.
  - The decode instruction is held; it is accepted the cycle after, with forwarding from EX/MEM.
- Forwarding is computed combinationally at capture, per source, with this priority:
  1. index==0 → 0
  2. fwd_mem_wen && fwd_mem_rd==idx → fwd_mem_data
  3. fwd_wb_wen && fwd_wb_rd==idx → fwd_wb_data
  4. otherwise → register-file data
- Operand mapping: ex_op0 = fwd(rs1); ex_op1 = dec_use_imm ? dec_imm : fwd(rs2); ex_rs2_data = fwd(rs2) always.
- Latency: exactly 1 cycle from accept to ex_valid; full throughput of 1 instruction/cycle with no hazard.
- Stall: ex_valid=1 && ex_ready=0 holds all ex_* outputs stable; dec_ready=0.
- Flush: next edge ex_valid=0; flush overrides accept, hazard and hold. Data outputs may keep stale values.
- Reset mid-operation: in-flight instruction is dropped and ex_valid clears immediately.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - Adds output perf_bubbles (32 bits): increments on every load-use bubble insertion, saturates at 0xFFFF_FFFF, resets to 0 on rst_n.
  - Adds output perf_flushes (32 bits): increments on every flush cycle where ex_valid was 1, saturates at 0xFFFF_FFFF, resets to 0 on rst_n.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package core_pkg:
  - XLEN and REG_AW constants
  - func3 encodings: F3_ADD=000, F3_SLL=001, F3_SLT=010, F3_XOR=100, F3_SRL=101, F3_OR=110, F3_AND=111
  - F7_SUB=0100000
  - id_ex_t struct bundling the ex_* payload
- Sub-module fwd_mux (one instance per source operand): index, rf data, two bypass ports → selected data.

Test Plan:
- Reset then dec_valid with rs1=1 (0x5), rs2=2 (0x7), use_imm=0, ex_ready=1 → next cycle ex_valid=1, ex_op0=5, ex_op1=7.
- rs1=3 with fwd_mem rd=3 data=0xAA and fwd_wb rd=3 data=0xBB → ex_op0=0xAA; with only wb matching → 0xBB; rs1=0 with fwd rd=0 → ex_op0=0.
- Load with rd=4 in EX, decode ADD rs1=4, ex_ready=1 → dec_ready=0, next cycle ex_valid=0 (bubble); following cycle ADD accepted with fwd_mem rd=4 data=0x10 → ex_op0=0x10.
- ex_ready=0 for 3 cycles with ex_valid=1 → ex_* stable, dec_ready=0; ex_ready=1 → next instruction captured.
- flush=1 while ex_valid=1 and dec_valid=1 → next cycle ex_valid=0, no accept; with ID_EX_PERF_EN, perf_flushes=1.
- Assert rst_n=0 asynchronously mid-stream → ex_valid=0 immediately, before the next clk edge.
